multi_cycle_adder: RTL and testbench
====================================

Name: multi_cycle_adder

Overview:
- Parametrised iterative adder/subtractor for measure-unit arithmetic.
- Splits a WIDTH-bit operation into NUM_CHUNKS = WIDTH/CHUNK chunks and computes one chunk per cycle with a ripple carry held in a flop, so timing closes at high clk_i.
- Adds a valid/ready handshake on both sides, a subtract mode, carry-in, and carry/overflow flags.
- Feeds timestamp difference and accumulation logic in the measure unit.

Parameters:
- WIDTH, 64: operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 16: bits computed per cycle. 1 <= CHUNK <= WIDTH.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous, active-high reset
- valid_i  input  1  operands valid
- ready_o  output  1  block can accept operands
- a_i  input  WIDTH  operand A
- b_i  input  WIDTH  operand B
- op_i  input  1  adder_pkg::op_e: ADD=0, SUB=1
- carry_i  input  1  carry-in; used for ADD only, ignored for SUB
- valid_o  output  1  result valid
- ready_i  input  1  downstream accepts result
- res_o  output  WIDTH  result
- carry_o  output  1  carry out of the MSB; for SUB, 1 = no borrow (a >= b unsigned)
- ovf_o  output  1  two's-complement signed overflow

Behaviour:
- Clock and reset:
  - One clock, clk_i.
  - Reset is asynchronous and active-high on rst_i.
  - All flops clear on rst_i: state=IDLE, valid_o=0, res_o=0, carry_o=0, ovf_o=0, chunk index=0, internal carry=0.
  - ready_o is 1 after reset.
- Accept:
  - Operands are accepted on a rising edge with valid_i && ready_o.
  - On accept, register a, b' (b' = ~b_i for SUB, b_i for ADD) and initial carry (1 for SUB, carry_i for ADD).
  - Inputs are not sampled at any other time.
- ready_o = (state==IDLE) || (state==DONE && ready_i). This allows back-to-back operation with no bubble beyond the compute cycles.
- States:
  - IDLE: on accept -> CALC, idx=0.
  - CALC: each edge writes res[idx*CHUNK +: CHUNK] = a_chunk + b'_chunk + carry, updates carry, idx++. On the edge where idx==NUM_CHUNKS-1, also register carry_o and ovf_o, then -> DONE.
    - ovf_o = carry into MSB XOR carry out of MSB.
  - DONE: valid_o=1. res_o, carry_o and ovf_o are stable while valid_o && !ready_i.
    - On ready_i: if valid_i, accept the new operands and go -> CALC; else -> IDLE. valid_o falls on that edge.
- Latency: valid_o rises NUM_CHUNKS cycles after the accept edge. Throughput is one result per NUM_CHUNKS+1 cycles with continuous ready_i.
- Outputs between operations:
  - res_o holds its last value in IDLE.
  - During CALC, res_o chunks update progressively; consumers must qualify with valid_o.
- NUM_CHUNKS==1: CALC lasts one cycle; behaviour is otherwise identical.
- valid_i while busy (CALC) is ignored; ready_o=0 during CALC. The upstream must hold its request.
- rst_i mid-CALC or mid-DONE aborts the operation immediately. No valid_o is produced for the aborted operation.
- Elaboration check: WIDTH % CHUNK != 0 → $error.

Decomposition:
- adder_pkg holds:
  - typedef enum logic {ADD, SUB} op_e
  - typedef enum logic [1:0] {IDLE, CALC, DONE} add_state_e
  - function clog2-based idx width helper
- Sub-module chunk_adder (param CHUNK): combinational CHUNK-bit sum with carry_in → sum, carry_out, and carry into the top bit (for overflow).
- multi_cycle_adder instantiates one chunk_adder, muxes the chunk by idx, and holds the FSM and registers.

Test Plan:
1. WIDTH=64, CHUNK=16, ADD 0x0000_0000_0000_FFFF + 0x1, carry_i=0 → valid_o 4 cycles after accept, res_o=0x0000_0000_0001_0000, carry_o=0, ovf_o=0.
2. ADD 0xFFFF_FFFF_FFFF_FFFF + 0x1 → res_o=0, carry_o=1, ovf_o=0. ADD 0x7FFF_FFFF_FFFF_FFFF + 0x1 → res_o=0x8000_0000_0000_0000, ovf_o=1.
3. SUB 5 − 7 with carry_i=1 (must be ignored) → res_o=0xFFFF_FFFF_FFFF_FFFE, carry_o=0, ovf_o=0. SUB 7 − 5 → res_o=2, carry_o=1.
4. Backpressure: ready_i=0 for 3 cycles after valid_o → valid_o, res_o and flags are stable, ready_o=0. Then ready_i=1 together with valid_i=1 (ADD 3+4) → same-edge accept, second result 7 after 4 more cycles.
5. Reset mid-op: assert rst_i asynchronously after 2 CALC edges → valid_o=0, res_o=0, ready_o=1 immediately. A subsequent ADD 1+1 → 2 with normal latency.
6. CHUNK=64, WIDTH=64: ADD 0x1+0x2 → res_o=3 one cycle after accept. valid_i asserted during CALC (CHUNK=16) → ignored, no extra result.

Source files
------------

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and sizing helper for the iterative adder
package adder_pkg;

    typedef enum logic {ADD, SUB} op_e;

    typedef enum logic [1:0] {IDLE, CALC, DONE} add_state_e;

    // Width of a counter/index able to address n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// rtl/chunk_adder.sv - combinational CHUNK-bit adder with carry into the top bit
module chunk_adder #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             carry_in,
    output logic [CHUNK-1:0] sum,
    output logic             carry_out,
    output logic             carry_msb
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, carry_in};

    // The carry entering the top bit is recovered from that bit's own sum.
    assign carry_msb = sum[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/multi_cycle_adder.sv
// rtl/multi_cycle_adder.sv - chunk-serial add/subtract with valid/ready on both sides
module multi_cycle_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             op_i,
    input  logic             carry_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o,
    output logic             ovf_o
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int IW         = idx_width(NUM_CHUNKS);
    localparam int BW         = idx_width(WIDTH);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_width_check
            $error("multi_cycle_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    add_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic [BW-1:0]    base;
    logic             accept, last;
    logic [CHUNK-1:0] sum;
    logic             c_out, c_msb;

    assign ready_o = (state_q == IDLE) || ((state_q == DONE) && ready_i);
    assign valid_o = (state_q == DONE);
    assign accept  = valid_i && ready_o;
    assign last    = (idx_q == IW'(NUM_CHUNKS - 1));
    assign base    = BW'(32'(idx_q) * CHUNK);

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a         (a_q[base +: CHUNK]),
        .b         (b_q[base +: CHUNK]),
        .carry_in  (carry_q),
        .sum       (sum),
        .carry_out (c_out),
        .carry_msb (c_msb)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_i) state_d = CALC;
            CALC:    if (last) state_d = DONE;
            DONE:    if (ready_i) state_d = valid_i ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            res_o   <= '0;
            carry_o <= 1'b0;
            ovf_o   <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1, so the operand is inverted once at capture.
            a_q     <= a_i;
            b_q     <= (op_e'(op_i) == SUB) ? ~b_i : b_i;
            carry_q <= (op_e'(op_i) == SUB) ? 1'b1 : carry_i;
            idx_q   <= '0;
        end else if (state_q == CALC) begin
            res_o[base +: CHUNK] <= sum;
            carry_q              <= c_out;
            idx_q                <= last ? '0 : idx_q + IW'(1);
            if (last) begin
                carry_o <= c_out;
                ovf_o   <= c_out ^ c_msb;
            end
        end
    end

endmodule

// File: tb/tb_multi_cycle_adder.sv
// tb/tb_multi_cycle_adder.sv - scoreboard bench for the iterative adder
module tb_multi_cycle_adder;

    typedef struct {
        logic [63:0] res;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i, ready_i, op_i, carry_i;
    logic [63:0] a_i, b_i;
    logic        ready_o, valid_o, carry_o, ovf_o;
    logic [63:0] res_o;

    logic        valid64_i;
    logic        ready64_o, valid64_o, carry64_o, ovf64_o;
    logic [63:0] res64_o;

    int errors = 0;
    int checks = 0;
    exp_t q[$];
    exp_t q64[$];

    always #5 clk_i = ~clk_i;

    multi_cycle_adder #(.WIDTH(64), .CHUNK(16)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .op_i(op_i), .carry_i(carry_i),
        .valid_o(valid_o), .ready_i(ready_i), .res_o(res_o),
        .carry_o(carry_o), .ovf_o(ovf_o)
    );

    multi_cycle_adder #(.WIDTH(64), .CHUNK(64)) u_dut64 (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid64_i), .ready_o(ready64_o),
        .a_i(a_i), .b_i(b_i), .op_i(op_i), .carry_i(carry_i),
        .valid_o(valid64_o), .ready_i(1'b1), .res_o(res64_o),
        .carry_o(carry64_o), .ovf_o(ovf64_o)
    );

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic op, input logic cin);
        exp_t e;
        logic [63:0] bv;
        logic [64:0] full;
        bv    = op ? ~b : b;
        full  = {1'b0, a} + {1'b0, bv} + {64'd0, (op ? 1'b1 : cin)};
        e.res = full[63:0];
        e.c   = full[64];
        e.v   = (a[63] == bv[63]) && (full[63] != a[63]);
        return e;
    endfunction

    // Drive one request on the 16-bit-chunk DUT until accepted; returns at accept edge + 1.
    task automatic send(input logic [63:0] a, input logic [63:0] b,
                        input logic op, input logic cin);
        int n = 0;
        a_i = a; b_i = b; op_i = op; carry_i = cin; valid_i = 1'b1;
        q.push_back(model(a, b, op, cin));
        @(negedge clk_i);
        while (!ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        @(posedge clk_i);
        #1 valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!valid_o && cyc < 50) begin
            @(posedge clk_i);
            #1 cyc++;
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1; valid_i = 1'b0; valid64_i = 1'b0; ready_i = 1'b1;
        a_i = '0; b_i = '0; op_i = 1'b0; carry_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready_o); end
        checks++; if (res_o !== 64'd0) begin errors++; $display("FAIL reset_res got=%h want=0", res_o); end
        checks++; if ({carry_o, ovf_o} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b want=00", {carry_o, ovf_o}); end
        rst_i = 1'b0;
    endtask

    task automatic run_one(input string name, input logic [63:0] a, input logic [63:0] b,
                           input logic op, input logic cin);
        int cyc;
        exp_t e;
        send(a, b, op, cin);
        wait_valid(cyc);
        e = q.pop_front();
        checks++; if (cyc !== 4) begin errors++; $display("FAIL %s_latency got=%0d want=4", name, cyc); end
        checks++; if (res_o !== e.res) begin errors++; $display("FAIL %s_res got=%h want=%h", name, res_o, e.res); end
        checks++; if ({carry_o, ovf_o} !== {e.c, e.v}) begin errors++; $display("FAIL %s_flags got=%b want=%b", name, {carry_o, ovf_o}, {e.c, e.v}); end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_add;
        run_one("add_carry16", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        run_one("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        run_one("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        run_one("add_cin", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1);
    endtask

    task automatic test_sub;
        run_one("sub_borrow", 64'd5, 64'd7, 1'b1, 1'b1);
        run_one("sub_pos", 64'd7, 64'd5, 1'b1, 1'b0);
        run_one("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back;
        int cyc;
        exp_t e;
        ready_i = 1'b0;
        send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        wait_valid(cyc);
        e = q.pop_front();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%b want=1", i, valid_o); end
            checks++; if (res_o !== e.res || carry_o !== e.c || ovf_o !== e.v) begin
                errors++; $display("FAIL bp_hold[%0d] got=%h/%b%b want=%h/%b%b", i, res_o, carry_o, ovf_o, e.res, e.c, e.v);
            end
            checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got=%b want=0", i, ready_o); end
        end
        ready_i = 1'b1;
        send(64'd3, 64'd4, 1'b0, 1'b0);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_valid_fall got=%b want=0", valid_o); end
        wait_valid(cyc);
        e = q.pop_front();
        checks++; if (cyc !== 4) begin errors++; $display("FAIL b2b_latency got=%0d want=4", cyc); end
        checks++; if (res_o !== e.res) begin errors++; $display("FAIL b2b_res got=%h want=%h", res_o, e.res); end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset_mid;
        send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b0);
        repeat (2) @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        void'(q.pop_front());
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b want=0", valid_o); end
        checks++; if (res_o !== 64'd0) begin errors++; $display("FAIL rstmid_res got=%h want=0", res_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b want=1", ready_o); end
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        run_one("after_rst", 64'd1, 64'd1, 1'b0, 1'b0);
    endtask

    task automatic test_busy_ignore;
        int cyc;
        int extra = 0;
        exp_t e;
        send(64'd100, 64'd23, 1'b0, 1'b0);
        a_i = 64'd999; b_i = 64'd999; valid_i = 1'b1;
        @(negedge clk_i);
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL busy_ready got=%b want=0", ready_o); end
        @(posedge clk_i);
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        wait_valid(cyc);
        e = q.pop_front();
        checks++; if (res_o !== e.res) begin errors++; $display("FAIL busy_res got=%h want=%h", res_o, e.res); end
        @(posedge clk_i);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (valid_o) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL busy_extra got=%0d want=0", extra); end
        #1;
    endtask

    task automatic test_single_chunk;
        exp_t e;
        @(posedge clk_i);
        #1;
        a_i = 64'h1; b_i = 64'h2; op_i = 1'b0; carry_i = 1'b0;
        q64.push_back(model(64'h1, 64'h2, 1'b0, 1'b0));
        checks++; if (ready64_o !== 1'b1) begin errors++; $display("FAIL c64_ready got=%b want=1", ready64_o); end
        valid64_i = 1'b1;
        @(posedge clk_i);
        #1 valid64_i = 1'b0;
        checks++; if (valid64_o !== 1'b0) begin errors++; $display("FAIL c64_calc_valid got=%b want=0", valid64_o); end
        @(posedge clk_i);
        #1;
        e = q64.pop_front();
        checks++; if (valid64_o !== 1'b1) begin errors++; $display("FAIL c64_valid got=%b want=1", valid64_o); end
        checks++; if (res64_o !== e.res) begin errors++; $display("FAIL c64_res got=%h want=%h", res64_o, e.res); end
        checks++; if ({carry64_o, ovf64_o} !== {e.c, e.v}) begin errors++; $display("FAIL c64_flags got=%b want=%b", {carry64_o, ovf64_o}, {e.c, e.v}); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_mid();
        test_busy_ignore();
        test_single_chunk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached without summary");
        $fatal(1);
    end

endmodule
